// File: rtl/interboard_rx_depacketizer.sv
// Receive-side depacketizer for the inter-board link: pops header/payload words from a
// show-ahead FIFO, emits payload words on a registered valid/ready port and counts framing errors.
module interboard_rx_depacketizer #(
    parameter int ERR_W = 8,
    parameter int PKT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdempty,
    input  logic [10:0]      q,
    output logic             rdreq,
    output logic [9:0]       out_data,
    output logic             out_dest,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [PKT_W-1:0] pkt_count,
    output logic             dbg_state
);

    typedef enum logic {
        S_HDR = 1'b0,
        S_PAY = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t     state;
    logic [3:0] rem;
    logic       dest;

    logic       is_hdr;
    logic       out_free;
    logic       hdr_pop;
    logic       pay_pop;
    logic       stray;
    logic       trunc;

    // Output handshake: a word transfers on a cycle where out_valid=1 and out_ready=1;
    // while out_valid=1 and out_ready=0 the word is held unchanged.
    assign is_hdr   = q[10];
    assign out_free = !out_valid || out_ready;
    assign hdr_pop  = (state == S_HDR) && !rdempty;
    assign pay_pop  = (state == S_PAY) && !rdempty && !is_hdr && out_free;
    assign stray    = (state == S_HDR) && !rdempty && !is_hdr;
    assign trunc    = (state == S_PAY) && !rdempty && is_hdr;

    // Headers never touch the output register, so they pop even under backpressure.
    assign rdreq     = reset && (hdr_pop || pay_pop);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_HDR;
            rem       <= 4'd0;
            dest      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_dest  <= 1'b0;
            out_data  <= 10'd0;
            err_pulse <= 1'b0;
            err_count <= '0;
            pkt_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (stray || trunc) begin
                err_pulse <= 1'b1;
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
            case (state)
                S_HDR: begin
                    if (hdr_pop && is_hdr && (q[3:0] != 4'd0)) begin
                        dest  <= q[9];
                        rem   <= q[3:0];
                        state <= S_PAY;
                    end
                end
                S_PAY: begin
                    // A header here means the packet was cut short; leave it for S_HDR.
                    if (trunc) begin
                        rem   <= 4'd0;
                        state <= S_HDR;
                    end else if (pay_pop) begin
                        out_data  <= q[9:0];
                        out_dest  <= dest;
                        out_last  <= (rem == 4'd1);
                        out_valid <= 1'b1;
                        rem       <= rem - 4'd1;
                        if (rem == 4'd1) begin
                            state     <= S_HDR;
                            pkt_count <= pkt_count + PKT_W'(1);
                        end
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: doc/interboard_rx_depacketizer.md
INTERBOARD_RX_DEPACKETIZER -- requirements
Module: interboard_rx_depacketizer

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, giving the width of the saturating error counter.
REQ-002 The block SHALL have parameter PKT_W, default 16, giving the width of the wrapping packet counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the same clock that reads the receive-board FIFO.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (one clock; reset asynchronous and active-low).
REQ-005 The block SHALL have port rdempty, input, 1 bit: receive FIFO empty.
REQ-006 The block SHALL have port q, input, 11 bits: FIFO head word, show-ahead (valid whenever rdempty=0).
REQ-007 The block SHALL have port rdreq, output, 1 bit: FIFO pop, combinational, asserted only when rdempty=0.
REQ-008 The block SHALL have port out_data, output, 10 bits: payload word.
REQ-009 The block SHALL have port out_dest, output, 1 bit: 0 = local core, 1 = forward to next board.
REQ-010 The block SHALL have port out_last, output, 1 bit: final payload word of the packet.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output word valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-013 The block SHALL have port err_pulse, output, 1 bit: one-cycle strobe per framing error.
REQ-014 The block SHALL have port err_count, output, ERR_W bits: saturating framing-error count.
REQ-015 The block SHALL have port pkt_count, output, PKT_W bits: completed packets, wraps.

Function
REQ-016 Word format SHALL be: q[10]=1 header, with q[9] = dest and q[3:0] = payload length N; q[10]=0 payload, with q[9:0] = data.
REQ-017 The FSM SHALL have two states, S_HDR and S_PAY, and SHALL hold a 4-bit remaining counter rem and a latched dest.
REQ-018 In S_HDR with rdempty=0 and q[10]=1 and N!=0, the block SHALL pop, latch dest and rem=N, and enter S_PAY next cycle.
REQ-019 In S_HDR, a header with N=0 SHALL be popped and discarded, with no error and no pkt_count change.
REQ-020 In S_HDR, a payload word (q[10]=0) SHALL be popped and discarded, pulse err_pulse, and increment err_count.
REQ-021 In S_PAY, the block SHALL pop only when rdempty=0, q[10]=0, and (out_valid=0 or out_ready=1).
REQ-022 On a payload pop, the output register SHALL load out_data=q[9:0], out_dest=dest, out_last=(rem==1), and out_valid=1, then decrement rem.
REQ-023 When rem reaches 0, the FSM SHALL return to S_HDR and increment pkt_count, in the same cycle out_last is loaded.
REQ-024 In S_PAY with q[10]=1 (truncated packet), the block SHALL NOT pop, SHALL pulse err_pulse, increment err_count, and go to S_HDR, so the header is reprocessed next cycle; pkt_count SHALL be unchanged.
REQ-025 Throughput SHALL be one payload word per cycle when out_ready=1 continuously; latency from pop to out_valid SHALL be 1 cycle.
REQ-026 When out_valid=1 and out_ready=0, out_data, out_dest, and out_last SHALL hold stable.
REQ-027 out_valid SHALL clear after a handshake cycle when no new word loads; simultaneous handshake and load SHALL keep out_valid=1 with the new word.
REQ-028 A header pop in S_HDR SHALL be permitted while out_valid=1 and out_ready=0, since it does not touch the output register.
REQ-029 err_count SHALL saturate at all-ones; pkt_count SHALL wrap from all-ones to 0.
REQ-030 rdreq SHALL never be asserted while rdempty=1.

Reset
REQ-031 When reset=0, the block SHALL asynchronously set state=S_HDR, rem=0, dest=0, out_valid=0, out_last=0, out_dest=0, out_data=0, err_pulse=0, err_count=0, pkt_count=0; rdreq SHALL evaluate to 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; after release, the FSM SHALL expect a header, and leftover payload words SHALL count as errors.
REQ-033 The first pop SHALL occur no earlier than the first rising clk edge after reset deasserts.

Verification
REQ-034 FIFO holds 0x403 (local, N=3), 0x011, 0x022, 0x033, out_ready=1 -> out_data 0x011/0x022/0x033 on consecutive cycles, out_dest=0, out_last only on 0x033, pkt_count=1.
REQ-035 Header 0x602 (forward, N=2), then 0x155, 0x2AA, with out_ready held 0 for 5 cycles -> first word held stable with out_dest=1, no second pop until ready, last on 0x2AA.
REQ-036 Stray 0x07F in S_HDR, then 0x401, 0x001 -> err_pulse one cycle, err_count=1, packet delivered normally, pkt_count=1.
REQ-037 0x403, 0x011, then 0x401, 0x0AB -> one error (truncation), 0x011 emitted without last, 0x0AB emitted with last, pkt_count=1.
REQ-038 300 stray payload words -> err_count=255 (saturated, ERR_W=8); header 0x400 -> no output, no count change.
REQ-039 reset pulsed low asynchronously after 1 of 3 payload words -> all outputs 0 immediately; remaining 2 words after release -> err_count=2.
